// File: rtl/bus_match_watch_pkg.sv
// Shared constants and helpers for the bus_match_watch compare block.
package bus_match_watch_pkg;

    localparam logic [1:0] CFG_VALUE = 2'd0;
    localparam logic [1:0] CFG_MASK  = 2'd1;
    localparam logic [1:0] CFG_CTRL  = 2'd2;
    localparam int unsigned CTRL_EN  = 0;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/bus_match_watch_if.sv
// Bus, config and status signals of bus_match_watch, grouped for port binding.
interface bus_match_watch_if
    import bus_match_watch_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
);
    localparam int unsigned SEL_W = sel_width(CHANNELS);

    logic                      en_n;
    logic [WIDTH-1:0]          data;
    logic                      data_valid;
    logic                      cfg_we;
    logic [SEL_W-1:0]          cfg_sel;
    logic [1:0]                cfg_addr;
    logic [WIDTH-1:0]          cfg_wdata;
    logic [CHANNELS-1:0]       hit_clr;
    logic [CHANNELS-1:0]       eq_n;
    logic                      any_eq_n;
    logic [CHANNELS-1:0]       hit;
    logic [CHANNELS*CNT_W-1:0] hit_cnt;

    modport master (
        output en_n, data, data_valid, cfg_we, cfg_sel, cfg_addr, cfg_wdata, hit_clr,
        input  eq_n, any_eq_n, hit, hit_cnt
    );

    modport slave (
        input  en_n, data, data_valid, cfg_we, cfg_sel, cfg_addr, cfg_wdata, hit_clr,
        output eq_n, any_eq_n, hit, hit_cnt
    );
endinterface

// File: rtl/bus_match_channel.sv
// One compare channel: value/mask/enable registers, masked compare,
// registered active-low match, sticky hit flag and saturating hit counter.
module bus_match_channel
    import bus_match_watch_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             qual,
    input  logic [WIDTH-1:0] data,
    input  logic             hit_clr,
    output logic             eq_n,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt
);
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] mask;
    logic             en;
    logic             match;

    always_comb begin
        match = en && qual && (((data ^ value) & mask) == '0);
    end

    // Same-cycle compares see the pre-write register contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
            mask  <= '1;
            en    <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                CFG_VALUE: value <= wr_data;
                CFG_MASK:  mask  <= wr_data;
                CFG_CTRL:  en    <= wr_data[CTRL_EN];
                default:   ;
            endcase
        end
    end

    // A match outranks a simultaneous clear: the count restarts at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_n    <= 1'b1;
            hit     <= 1'b0;
            hit_cnt <= '0;
        end else begin
            eq_n <= ~match;
            if (match) begin
                hit <= 1'b1;
                if (hit_clr)
                    hit_cnt <= CNT_W'(1);
                else if (hit_cnt != '1)
                    hit_cnt <= hit_cnt + 1'b1;
            end else if (hit_clr) begin
                hit     <= 1'b0;
                hit_cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/bus_match_watch.sv
// N-channel masked equality watcher: config decode, global qualification,
// per-channel compare instances and status packing.
module bus_match_watch
    import bus_match_watch_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8
) (
    input logic               clk,
    input logic               rst_n,
    bus_match_watch_if.slave  bus
);
    logic                qual;
    logic [CHANNELS-1:0] wr_en;
    logic [CHANNELS-1:0] eq_n;
    logic [CHANNELS-1:0] hit;

    always_comb begin
        qual = bus.data_valid && !bus.en_n;
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            // Out-of-range selects never equal a channel index, so they drop out.
            assign wr_en[i] = bus.cfg_we && (32'(bus.cfg_sel) == i);

            bus_match_channel #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_ch (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en   (wr_en[i]),
                .wr_addr (bus.cfg_addr),
                .wr_data (bus.cfg_wdata),
                .qual    (qual),
                .data    (bus.data),
                .hit_clr (bus.hit_clr[i]),
                .eq_n    (eq_n[i]),
                .hit     (hit[i]),
                .hit_cnt (bus.hit_cnt[i*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign bus.eq_n     = eq_n;
    assign bus.hit      = hit;
    assign bus.any_eq_n = &eq_n;
endmodule

// File: tb/tb_bus_match_watch.sv
// Self-checking bench for bus_match_watch: directed scenarios plus randomized
// traffic compared against a behavioural model of the channel rules.
module tb_bus_match_watch;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 4;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned CMAX     = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bus_match_watch_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

    bus_match_watch #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state
    logic [WIDTH-1:0]    m_val [CHANNELS];
    logic [WIDTH-1:0]    m_msk [CHANNELS];
    bit                  m_en  [CHANNELS];
    bit                  m_hit [CHANNELS];
    int unsigned         m_cnt [CHANNELS];
    logic [CHANNELS-1:0] m_eq_n;

    function automatic logic [CNT_W-1:0] cnt_of(input int unsigned ch);
        return bus.hit_cnt[ch*CNT_W +: CNT_W];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CHANNELS; c++) begin
            m_val[c] = '0;
            m_msk[c] = '1;
            m_en[c]  = 0;
            m_hit[c] = 0;
            m_cnt[c] = 0;
        end
        m_eq_n = '1;
    endtask

    // Evaluate one clock using the inputs currently driven.
    task automatic model_step();
        bit m;
        for (int c = 0; c < CHANNELS; c++) begin
            m = m_en[c] && bus.data_valid && !bus.en_n &&
                (((bus.data ^ m_val[c]) & m_msk[c]) == 0);
            m_eq_n[c] = !m;
            if (m) begin
                m_hit[c] = 1;
                m_cnt[c] = bus.hit_clr[c] ? 1 : ((m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX);
            end else if (bus.hit_clr[c]) begin
                m_hit[c] = 0;
                m_cnt[c] = 0;
            end
        end
        if (bus.cfg_we && int'(bus.cfg_sel) < CHANNELS) begin
            case (bus.cfg_addr)
                2'd0: m_val[bus.cfg_sel] = bus.cfg_wdata;
                2'd1: m_msk[bus.cfg_sel] = bus.cfg_wdata;
                2'd2: m_en[bus.cfg_sel]  = bus.cfg_wdata[0];
                default: ;
            endcase
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int unsigned sel, input logic [1:0] addr, input logic [7:0] wd);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = sel[1:0];
        bus.cfg_addr  = addr;
        bus.cfg_wdata = wd;
        step();
        bus.cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.en_n       = 1'b0;
        bus.data       = 8'hA5;
        bus.data_valid = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.cfg_sel    = '0;
        bus.cfg_addr   = '0;
        bus.cfg_wdata  = '0;
        bus.hit_clr    = '0;
        model_reset();
        #12;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.eq_n !== 4'b1111) begin
            errors++; $display("FAIL reset_eq_n: got %b expected 1111", bus.eq_n);
        end
        checks++;
        if (bus.any_eq_n !== 1'b1) begin
            errors++; $display("FAIL reset_any_eq_n: got %b expected 1", bus.any_eq_n);
        end
        checks++;
        if (bus.hit_cnt !== '0 || bus.hit !== '0) begin
            errors++; $display("FAIL reset_counters: got cnt %h hit %b expected 0", bus.hit_cnt, bus.hit);
        end
    endtask

    task automatic test_exact_match();
        bus.data_valid = 1'b0;
        cfg_write(0, 2'd0, 8'h3C);
        cfg_write(0, 2'd1, 8'hFF);
        cfg_write(0, 2'd2, 8'h01);
        bus.data_valid = 1'b1;
        bus.data = 8'h3C;
        step();
        checks++;
        if (bus.eq_n[0] !== 1'b0 || bus.any_eq_n !== 1'b0) begin
            errors++; $display("FAIL exact_hit: got eq_n %b any %b expected eq_n[0]=0 any=0", bus.eq_n, bus.any_eq_n);
        end
        bus.data = 8'h3D;
        step();
        checks++;
        if (bus.eq_n !== 4'b1111) begin
            errors++; $display("FAIL exact_release: got %b expected 1111", bus.eq_n);
        end
        checks++;
        if (bus.hit[0] !== 1'b1 || cnt_of(0) !== 2'd1) begin
            errors++; $display("FAIL exact_count: got hit %b cnt %0d expected 1 1", bus.hit[0], cnt_of(0));
        end
    endtask

    task automatic test_mask();
        bus.data_valid = 1'b0;
        cfg_write(1, 2'd0, 8'h30);
        cfg_write(1, 2'd1, 8'hF0);
        cfg_write(1, 2'd2, 8'h01);
        bus.data_valid = 1'b1;
        bus.data = 8'h3F;
        step();
        checks++;
        if (bus.eq_n !== 4'b1101) begin
            errors++; $display("FAIL mask_hit: got %b expected 1101", bus.eq_n);
        end
        bus.data = 8'h4F;
        step();
        checks++;
        if (bus.eq_n !== 4'b1111 || cnt_of(1) !== 2'd1) begin
            errors++; $display("FAIL mask_miss: got eq_n %b cnt1 %0d expected 1111 1", bus.eq_n, cnt_of(1));
        end
    endtask

    task automatic test_gating();
        bus.en_n = 1'b1;
        bus.data = 8'h3C;
        bus.data_valid = 1'b1;
        step();
        checks++;
        if (bus.eq_n !== 4'b1111 || cnt_of(0) !== 2'd1) begin
            errors++; $display("FAIL gate_en_n: got eq_n %b cnt0 %0d expected 1111 1", bus.eq_n, cnt_of(0));
        end
        bus.en_n = 1'b0;
        bus.data_valid = 1'b0;
        step();
        checks++;
        if (bus.eq_n !== 4'b1111 || cnt_of(0) !== 2'd1 || cnt_of(1) !== 2'd1) begin
            errors++; $display("FAIL gate_valid: got eq_n %b cnt %h expected 1111 cnt0=1 cnt1=1", bus.eq_n, bus.hit_cnt);
        end
    endtask

    task automatic test_saturation();
        bus.data_valid = 1'b1;
        bus.data = 8'h3C;
        repeat (4) step();
        checks++;
        if (cnt_of(0) !== 2'd3) begin
            errors++; $display("FAIL sat_reach: got %0d expected 3", cnt_of(0));
        end
        step();
        checks++;
        if (cnt_of(0) !== 2'd3) begin
            errors++; $display("FAIL sat_hold: got %0d expected 3", cnt_of(0));
        end
        bus.hit_clr = 4'b0001;
        step();
        checks++;
        if (bus.hit[0] !== 1'b1 || cnt_of(0) !== 2'd1) begin
            errors++; $display("FAIL clr_race: got hit %b cnt %0d expected 1 1", bus.hit[0], cnt_of(0));
        end
        bus.data = 8'h00;
        step();
        checks++;
        if (bus.hit[0] !== 1'b0 || cnt_of(0) !== 2'd0) begin
            errors++; $display("FAIL clr_plain: got hit %b cnt %0d expected 0 0", bus.hit[0], cnt_of(0));
        end
        bus.hit_clr = '0;
        bus.data_valid = 1'b0;
        cfg_write(1, 2'd2, 8'h00);
        bus.hit_clr = 4'b0010;
        step();
        bus.hit_clr = '0;
        checks++;
        if (bus.hit[1] !== 1'b0 || cnt_of(1) !== 2'd0) begin
            errors++; $display("FAIL clr_disabled: got hit %b cnt %0d expected 0 0", bus.hit[1], cnt_of(1));
        end
    endtask

    task automatic test_write_race();
        bus.data_valid = 1'b0;
        cfg_write(2, 2'd2, 8'h01);
        bus.data_valid = 1'b1;
        bus.data = 8'h11;
        cfg_write(2, 2'd0, 8'h11);
        checks++;
        if (bus.eq_n[2] !== 1'b1) begin
            errors++; $display("FAIL race_old_value: got %b expected 1", bus.eq_n[2]);
        end
        step();
        checks++;
        if (bus.eq_n[2] !== 1'b0) begin
            errors++; $display("FAIL race_new_value: got %b expected 0", bus.eq_n[2]);
        end
        cfg_write(2, 2'd3, 8'h22);
        step();
        checks++;
        if (bus.eq_n[2] !== 1'b0) begin
            errors++; $display("FAIL rsvd_noop: got %b expected 0", bus.eq_n[2]);
        end
        cfg_write(2, 2'd2, 8'hFE);
        step();
        checks++;
        if (bus.eq_n[2] !== 1'b1) begin
            errors++; $display("FAIL ctrl_bit0: got %b expected 1", bus.eq_n[2]);
        end
    endtask

    task automatic test_random();
        int unsigned c;
        for (int n = 0; n < 400; n++) begin
            bus.en_n       = ($urandom_range(0, 7) == 0);
            bus.data_valid = ($urandom_range(0, 7) != 0);
            c = $urandom_range(0, CHANNELS - 1);
            if ($urandom_range(0, 1) == 1)
                bus.data = m_val[c] ^ (8'($urandom) & ~m_msk[c]);
            else
                bus.data = 8'($urandom);
            bus.cfg_we    = ($urandom_range(0, 5) == 0);
            bus.cfg_sel   = 2'($urandom);
            bus.cfg_addr  = 2'($urandom);
            bus.cfg_wdata = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
            if (bus.cfg_addr == 2'd2)
                bus.cfg_wdata = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom) | 8'h01;
            bus.hit_clr = ($urandom_range(0, 9) == 0) ? 4'($urandom) : '0;
            step();
            checks++;
            if (bus.eq_n !== m_eq_n || bus.any_eq_n !== (&m_eq_n)) begin
                errors++; $display("FAIL rand_eq[%0d]: got %b/%b expected %b/%b", n, bus.eq_n, bus.any_eq_n, m_eq_n, &m_eq_n);
            end
            for (int k = 0; k < CHANNELS; k++) begin
                checks++;
                if (bus.hit[k] !== m_hit[k] || int'(cnt_of(k)) != m_cnt[k]) begin
                    errors++; $display("FAIL rand_ch%0d[%0d]: got hit %b cnt %0d expected %0d %0d", k, n, bus.hit[k], cnt_of(k), m_hit[k], m_cnt[k]);
                end
            end
        end
        bus.cfg_we = 1'b0;
        bus.hit_clr = '0;
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < CHANNELS; c++)
            cfg_write(c, 2'd1, 8'h00);
        for (int c = 0; c < CHANNELS; c++)
            cfg_write(c, 2'd2, 8'h01);
        bus.en_n = 1'b0;
        bus.data_valid = 1'b1;
        step();
        step();
        checks++;
        if (bus.eq_n !== 4'b0000 || bus.hit !== 4'b1111) begin
            errors++; $display("FAIL pre_reset_active: got eq_n %b hit %b expected 0000 1111", bus.eq_n, bus.hit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.eq_n !== 4'b1111 || bus.any_eq_n !== 1'b1 || bus.hit !== '0 || bus.hit_cnt !== '0) begin
            errors++; $display("FAIL async_reset: got eq_n %b any %b hit %b cnt %h expected 1111 1 0 0", bus.eq_n, bus.any_eq_n, bus.hit, bus.hit_cnt);
        end
        model_reset();
        #4;
        rst_n = 1'b1;
        bus.data = 8'h3C;
        step();
        checks++;
        if (bus.eq_n !== 4'b1111 || bus.hit !== '0) begin
            errors++; $display("FAIL post_reset_disabled: got eq_n %b hit %b expected 1111 0000", bus.eq_n, bus.hit);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exact_match();
        test_mask();
        test_gating();
        test_saturation();
        test_write_race();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_match_watch.md
# bus_match_watch

Parametrised, registered successor to the 8-bit identity-comparator parts on the simulated TTL boards. It is an N-channel masked equality watcher on a CPU bus. Each channel holds a programmable compare value, bit mask and enable, and produces a registered active-low match. Each channel also keeps a sticky hit flag and a saturating hit counter. It sits on the simulation board as a bus probe and breakpoint source.

## Interface
- WIDTH, 8: compared bus width (≥1).
- CHANNELS, 4: number of independent compare channels (1–16).
- CNT_W, 8: hit-counter width per channel.
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_n  in  1  active-low global compare enable, equivalent to the /G pin; high suppresses all compares.
- data  in  WIDTH  bus value under test.
- data_valid  in  1  data is meaningful this cycle.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  $clog2(CHANNELS) (min 1)  target channel.
- cfg_addr  in  2  register select: 0 = value, 1 = mask, 2 = ctrl (bit0 = channel enable), 3 = reserved.
- cfg_wdata  in  WIDTH  write data.
- hit_clr  in  CHANNELS  per-channel clear of sticky flag and counter.
- eq_n  out  CHANNELS  registered active-low match per channel.
- any_eq_n  out  1  AND of eq_n, i.e. low if any channel matches.
- hit  out  CHANNELS  sticky hit flags.
- hit_cnt  out  CHANNELS*CNT_W  packed saturating counters; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- Compare condition for channel i: `((data ^ value_i) & mask_i) == 0`, qualified by `ctrl_i.en & data_valid & ~en_n`.
  - Mask bit 1 means the bit is compared; mask bit 0 means don't-care.
  - A mask of all zeros matches any qualified cycle.
- eq_n[i] is registered: it is low in the cycle after a qualified match and high otherwise. There is no hold; every cycle is re-evaluated.
- hit[i] sets on a qualified match and stays set until hit_clr[i].
- hit_cnt[i] increments on each qualified match and saturates at 2^CNT_W−1.
- Config writes:
  - A write takes effect at the clock edge.
  - A compare in the same cycle as a write to that channel uses the old register contents.
  - cfg_addr 3, or cfg_sel ≥ CHANNELS, makes the write a no-op.
  - Only bit0 of cfg_wdata is stored for ctrl.
- hit_clr[i] together with a match in the same cycle: the set wins, giving hit = 1 and hit_cnt = 1.
- hit_clr on a channel that is disabled clears it normally.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - value = 0, mask = all ones, ctrl.en = 0.
  - eq_n = all ones, any_eq_n = 1, hit = 0, hit_cnt = 0.
- Latency: data/valid to eq_n and any_eq_n is 1 cycle. Match to hit and hit_cnt update is also 1 cycle, on the same edge as eq_n.
- Throughput: one compare per cycle per channel. There is no back-pressure.
- en_n high or data_valid low: eq_n is all ones on the next edge. Counters and flags hold.
- Reset asserted mid-operation clears everything immediately, with no wait for a clock. First compare after release: the first rising edge with rst_n high. Channels are disabled until reprogrammed.
- Counter wrap: none. The counter holds at the maximum value until cleared.

## Structure
- Package bus_match_watch_pkg:
  - cfg_addr constants CFG_VALUE = 2'd0, CFG_MASK = 2'd1, CFG_CTRL = 2'd2.
  - Ctrl bit index CTRL_EN = 0.
  - Sel-width helper function, returning max(1, clog2(CHANNELS)).
- Sub-module bus_match_channel, instantiated CHANNELS times via generate:
  - Holds value/mask/en.
  - Contains the masked compare, eq_n register, sticky flag and saturating counter.
  - Inputs: local write strobe and data, the broadcast qualified-data signal, and hit_clr bit.
- Top level: cfg decode, en_n/data_valid qualification, any_eq_n reduction and hit_cnt packing.

## Test plan
- Reset then idle: drive data = 8'hA5, valid = 1, en_n = 0 with no channels enabled → eq_n = 4'b1111, any_eq_n = 1, all counters 0.
- Program ch0 with value = 8'h3C, mask = 8'hFF, en = 1. Drive 8'h3C then 8'h3D → eq_n[0] is low for exactly one cycle, one cycle after 8'h3C; hit[0] = 1; hit_cnt[0] = 1.
- Masking: ch1 value = 8'h30, mask = 8'hF0, en = 1. Drive 8'h3F, 8'h4F → ch1 matches only on 8'h3F; hit_cnt[1] = 1.
- Gating: hold en_n = 1 while driving matching data, then drop data_valid → no eq_n assertion, counters unchanged.
- Saturation and clear race: CNT_W = 2, with four consecutive matches → hit_cnt = 3, holding. Then hit_clr[0] asserted in the same cycle as a match → hit = 1, hit_cnt = 1.
- Write/compare race and async reset:
  - Write ch2 value = 8'h11 in the same cycle as data = 8'h11 → no match that cycle; match on the next 8'h11.
  - Assert rst_n low between clock edges → all outputs return to reset values before the next edge.
